// File: rtl/mem_ctrl_wbuf_pkg.sv
// rtl/mem_ctrl_wbuf_pkg.sv - shared encodings, default widths and state type for the write-buffered memory controller
package mem_ctrl_wbuf_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] ACT_RD = 2'b01;
  localparam logic [1:0] ACT_WR = 2'b10;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } ctrl_state_e;

  function automatic logic is_legal_action(input logic [1:0] act);
    return (act == ACT_RD) || (act == ACT_WR);
  endfunction

endpackage

// File: rtl/mem_ctrl_wbuf_wbuf.sv
// rtl/mem_ctrl_wbuf_wbuf.sv - circular write buffer with parallel address search, youngest match wins
module mem_wbuf #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PW  = $clog2(DEPTH),
  localparam int PW1 = PW + 1,
  localparam int CW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  input  logic [ADDR_W-1:0] search_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [PW:0]       idx_sum;
  logic [PW-1:0]     idx;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Walk oldest to youngest so the last live match overrides earlier ones.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx_sum  = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_sum = {1'b0, rd_ptr} + PW1'(k);
      idx     = (idx_sum >= PW1'(DEPTH)) ? PW'(idx_sum - PW1'(DEPTH)) : PW'(idx_sum);
      if ((CW'(k) < cnt) && (addr_mem[idx] == search_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign count     = cnt;
  assign full      = (cnt == CW'(DEPTH));
  assign empty     = (cnt == '0);

endmodule

// File: rtl/mem_ctrl_wbuf.sv
// rtl/mem_ctrl_wbuf.sv - pipelined memory controller: port arbiter, in-order return pipe, RUN/FLUSH control
module mem_ctrl_wbuf
  import mem_ctrl_wbuf_pkg::*;
#(
  parameter int DATA_W     = DATA_WIDTH,
  parameter int ADDR_W     = DATA_WIDTH,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [1:0]        i_action,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_rvalid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic              o_wbuf_empty,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data
);

  localparam int CW = $clog2(WBUF_DEPTH + 1);

  ctrl_state_e       state;
  ctrl_state_e       state_next;
  logic              ready_en;
  logic              accept;
  logic              is_rd;
  logic              is_wr;
  logic              is_ill;
  logic              rd_miss;
  logic              drain;
  logic              wb_hit;
  logic [DATA_W-1:0] wb_hit_data;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     wb_count;
  logic              wb_full;
  logic              wb_empty;
  logic [RD_LATENCY-1:0] pipe_valid;
  logic [RD_LATENCY-1:0] pipe_hit;
  logic [DATA_W-1:0] pipe_data [RD_LATENCY];
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] data_hold;
  logic              err_q;

  // ready_en keeps o_ready low while reset is applied and for the first clock after release.
  assign o_ready = ready_en && (state == ST_RUN) && !wb_full;
  assign accept  = i_valid && o_ready;
  assign is_rd   = accept && (i_action == ACT_RD);
  assign is_wr   = accept && (i_action == ACT_WR);
  assign is_ill  = accept && !is_legal_action(i_action);
  assign rd_miss = is_rd && !wb_hit;

  // Slot is idle when no read miss owns the port and no write is being posted; full/FLUSH force this.
  assign drain = !wb_empty && !rd_miss && !is_wr;

  mem_wbuf #(
    .DEPTH (WBUF_DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (is_wr),
    .pop        (drain),
    .push_addr  (i_address),
    .push_data  (i_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .search_addr(i_address),
    .hit        (wb_hit),
    .hit_data   (wb_hit_data),
    .count      (wb_count),
    .full       (wb_full),
    .empty      (wb_empty)
  );

  assign mem_r_en   = rd_miss;
  assign mem_r_addr = rd_miss ? i_address : '0;
  assign mem_w_en   = drain;
  assign mem_w_addr = drain ? head_addr : '0;
  assign mem_w_data = drain ? head_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_hit   <= '0;
      for (int s = 0; s < RD_LATENCY; s++) pipe_data[s] <= '0;
    end else begin
      pipe_valid[0] <= is_rd;
      pipe_hit[0]   <= is_rd && wb_hit;
      pipe_data[0]  <= wb_hit_data;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_hit[s]   <= pipe_hit[s-1];
        pipe_data[s]  <= pipe_data[s-1];
      end
    end
  end

  assign o_rvalid = pipe_valid[RD_LATENCY-1];
  assign ret_data = pipe_hit[RD_LATENCY-1] ? pipe_data[RD_LATENCY-1] : mem_r_data;
  assign o_data   = o_rvalid ? ret_data : data_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ready_en  <= 1'b0;
      err_q     <= 1'b0;
      data_hold <= '0;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      err_q    <= is_ill;
      if (o_rvalid) data_hold <= ret_data;
    end
  end

  always_comb begin
    state_next   = state;
    o_flush_done = 1'b0;
    case (state)
      ST_RUN: begin
        if (i_flush) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((wb_count == '0) && !drain) begin
          state_next   = ST_RUN;
          o_flush_done = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign o_err        = err_q;
  assign o_wbuf_empty = wb_empty;

endmodule
